// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter
// Packet-level round-robin arbiter that places NUM_SRC AXI-Stream byte
// sources in front of a single AXI-Stream -> UART transmit bridge. A grant
// is held for a whole packet, which ends on tlast or at MAX_PKT_LEN bytes,
// so bytes from different sources never interleave on the UART line.
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]          s_axis_valid,
    input  logic [NUM_SRC-1:0]          s_axis_last,
    output logic [NUM_SRC-1:0]          s_axis_ready,
    output logic [DATA_W-1:0]           m_axis_data,
    output logic                        m_axis_valid,
    output logic                        m_axis_last,
    input  logic                        m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0]  grant_id,
    output logic                        busy,
    output logic                        trunc_pulse
);

    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_PKT_LEN);

    // Byte index at which the current byte is forced to carry last.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SRC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  byte_cnt;

    logic              any_req;
    logic              req_found;
    logic [ID_W-1:0]   req_idx;
    logic              xfer;
    logic              granted_last;
    logic              at_limit;
    logic              handshake;
    logic              final_hs;

    assign any_req      = |s_axis_valid;
    assign xfer         = (state == XFER);
    assign granted_last = s_axis_last[grant_id];
    assign at_limit     = (byte_cnt == LAST_CNT);
    assign handshake    = m_axis_valid & m_axis_ready;
    assign final_hs     = handshake & m_axis_last;

    // Round-robin search: first requesting source at or after rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the block leaves it unassigned and infers a latch.
        int idx;
        idx       = 0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SRC;
            if (!req_found && s_axis_valid[idx]) begin
                req_found = 1'b1;
                req_idx   = ID_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one arbitration cycle, then hold until the packet ends.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (any_req)  state_next = XFER;
            XFER: if (final_hs) state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // Output logic: combinational pass-through of the granted source in XFER.
    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        if (xfer) begin
            m_axis_data            = s_axis_data[grant_id*DATA_W +: DATA_W];
            m_axis_valid           = s_axis_valid[grant_id];
            m_axis_last            = granted_last | at_limit;
            s_axis_ready[grant_id] = m_axis_ready;
        end
    end

    // Grant bookkeeping: grant capture, byte counting, pointer advance, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            byte_cnt    <= '0;
            busy        <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            // The pulse is raised only by a forced-last handshake, else clear.
            trunc_pulse <= handshake & at_limit & ~granted_last;

            if (!xfer) begin
                if (any_req && req_found) begin
                    grant_id <= req_idx;
                    busy     <= 1'b1;
                    byte_cnt <= '0;
                end
            end else begin
                if (handshake) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
                if (final_hs) begin
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end

endmodule
